// File: rtl/fifo_word_reader_pkg.sv
// Shared types and defaults for the FIFO word reader.
// The defaults must match the byte FIFO instantiation.
package fifo_word_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    OUT   = 2'd3
  } rd_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PACK_BYTES = 2;

endpackage

// File: rtl/fifo_word_packer.sv
// Lane shift register and byte counter for the word reader.
// A byte is written into lane [cnt]; o_full flags the final byte.
module fifo_word_packer
  import fifo_word_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_BYTES = DEF_PACK_BYTES,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_shift,
  input  logic                             i_clr,
  input  logic [DATA_WIDTH-1:0]            i_byte,
  output logic [DATA_WIDTH*PACK_BYTES-1:0] o_lanes,
  output logic [DATA_WIDTH*PACK_BYTES-1:0] o_next,
  output logic [CNT_WIDTH-1:0]             o_cnt,
  output logic                             o_full
);

  localparam int WW = DATA_WIDTH * PACK_BYTES;

  logic [WW-1:0]        r_lanes;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WW-1:0]        w_ins;

  always_comb begin
    w_ins = r_lanes;
    for (int i = 0; i < PACK_BYTES; i++) begin
      if (r_cnt == CNT_WIDTH'(i)) begin
        w_ins[i*DATA_WIDTH +: DATA_WIDTH] = i_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_lanes <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_lanes <= w_ins;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_lanes = r_lanes;
  assign o_next  = w_ins;
  assign o_cnt   = r_cnt;
  assign o_full  = i_shift &&
                   (r_cnt == CNT_WIDTH'(PACK_BYTES - 1));

endmodule

// File: rtl/fifo_word_reader.sv
// Drains a byte FIFO and packs bytes little-endian into words.
// FIFO_WORD_TIMEOUT_EN enables the idle partial-word flush.
module fifo_word_reader
  import fifo_word_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PACK_BYTES     = DEF_PACK_BYTES,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_cs,
  output logic                             fifo_rd_en,
  output logic [DATA_WIDTH*PACK_BYTES-1:0] word_data,
  output logic [CNT_WIDTH-1:0]             word_bytes,
  output logic                             word_valid,
  input  logic                             word_ready
);

  localparam int WW = DATA_WIDTH * PACK_BYTES;

  rd_state_t            r_state;
  rd_state_t            w_next_state;
  logic [WW-1:0]        w_pk_lanes;
  logic [WW-1:0]        w_pk_next;
  logic [CNT_WIDTH-1:0] w_pk_cnt;
  logic                 w_pk_full;
  logic                 w_shift;
  logic                 w_clr;
  logic                 w_tmo_hit;
  logic                 w_strobe;
  logic                 w_load_full;
  logic                 w_load_part;
  logic                 w_accept;

  assign w_shift  = (r_state == LATCH);
  assign w_accept = (r_state == OUT) && word_ready;
  assign w_clr    = w_accept;

  fifo_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_BYTES (PACK_BYTES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_clr   (w_clr),
    .i_byte  (fifo_data),
    .o_lanes (w_pk_lanes),
    .o_next  (w_pk_next),
    .o_cnt   (w_pk_cnt),
    .o_full  (w_pk_full)
  );

`ifdef FIFO_WORD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo;
  logic             w_tmo_run;

  // Only a stranded partial word with nothing left to read ages.
  assign w_tmo_run = (r_state == IDLE) && (w_pk_cnt != '0) &&
                     fifo_empty;
  assign w_tmo_hit = w_tmo_run &&
                     (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_tmo_run) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  wire w_unused_tmo = (TIMEOUT_CYCLES == 0) | (|w_pk_lanes) |
                      (|w_pk_cnt);
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_next_state = READ;
        end else if (w_tmo_hit) begin
          w_next_state = OUT;
        end
      end
      READ:  w_next_state = LATCH;
      LATCH: w_next_state = w_pk_full ? OUT : IDLE;
      OUT:   w_next_state = word_ready ? IDLE : OUT;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_strobe    = (w_next_state == READ);
    w_load_full = (r_state == LATCH) && w_pk_full;
    w_load_part = (r_state == IDLE) && fifo_empty && w_tmo_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_cs <= 1'b0;
      fifo_rd_en <= 1'b0;
      word_data  <= '0;
      word_bytes <= '0;
      word_valid <= 1'b0;
    end else begin
      fifo_rd_cs <= w_strobe;
      fifo_rd_en <= w_strobe;
      if (w_load_full) begin
        word_data  <= w_pk_next;
        word_bytes <= CNT_WIDTH'(PACK_BYTES);
        word_valid <= 1'b1;
      end else if (w_load_part) begin
        word_data  <= w_pk_lanes;
        word_bytes <= w_pk_cnt;
        word_valid <= 1'b1;
      end else if (w_accept) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed and random scoreboard bench for fifo_word_reader.
// Bench-side byte FIFO model with registered read data.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_cs;
  logic        fifo_rd_en;
  logic [15:0] word_data;
  logic [3:0]  word_bytes;
  logic        word_valid;
  logic        word_ready = 1'b0;

  logic        push_en = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic [7:0]  fq[$];

  typedef struct {
    logic [15:0] d;
    logic [3:0]  n;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int v_cnt = 0;

  logic [15:0] sb_part = 16'h0;
  int          sb_n = 0;

  logic        prev_rd = 1'b0;
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_d = 16'h0;

  fifo_word_reader #(
    .DATA_WIDTH     (8),
    .PACK_BYTES     (2),
    .CNT_WIDTH      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_cs (fifo_rd_cs),
    .fifo_rd_en (fifo_rd_en),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_rd_cs && fq.size() != 0) begin
      fifo_data <= fq.pop_front();
    end
    if (push_en) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_single", {31'd0, prev_rd}, 32'd0);
        chk("pop_empty", {31'd0, fifo_empty}, 32'd0);
        chk("cs_eq_en", {31'd0, fifo_rd_cs}, 32'd1);
      end
      if (word_valid) v_cnt++;
      if (prev_v && !prev_rdy) begin
        chk("hold_valid", {31'd0, word_valid}, 32'd1);
        chk("hold_data", {16'd0, word_data}, {16'd0, prev_d});
      end
      if (word_valid && word_ready) begin
        chk("sb_have", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_data", {16'd0, word_data}, {16'd0, e.d});
          chk("word_bytes", {28'd0, word_bytes}, {28'd0, e.n});
        end
      end
    end
    prev_rd  = fifo_rd_en;
    prev_v   = word_valid;
    prev_rdy = word_ready;
    prev_d   = word_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_byte(input logic [7:0] b);
    if (sb_n == 0) sb_part = {8'h00, b};
    else sb_part[15:8] = b;
    sb_n++;
    if (sb_n == 2) begin
      exp_q.push_back('{d: sb_part, n: 4'd2});
      sb_n = 0;
      sb_part = 16'h0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_en = 1'b1;
    push_data = b;
    sb_byte(b);
    tick();
    push_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    int r0;
    bit seen;
    logic [7:0] b;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_cs", {31'd0, fifo_rd_cs}, 32'd0);
    chk("rst_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_data", {16'd0, word_data}, 32'd0);
    chk("rst_bytes", {28'd0, word_bytes}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    tick();
    rst = 1'b0;

    // basic two-byte word
    word_ready = 1'b1;
    rd_cnt = 0;
    v_cnt = 0;
    push(8'h34);
    push(8'h12);
    drain(100);
    repeat (5) tick();
    chk("t1_pulses", rd_cnt, 32'd2);
    chk("t1_vcycles", v_cnt, 32'd1);

    // backpressure
    word_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (word_valid) seen = 1;
    end
    chk("t2_valid_seen", {31'd0, seen}, 32'd1);
    tick();
    r0 = rd_cnt;
    repeat (10) tick();
    @(negedge clk);
    chk("t2_hold", {16'd0, word_data}, 32'h0201);
    chk("t2_no_pop", rd_cnt, r0);
    tick();
    word_ready = 1'b1;
    drain(200);

    // idle with empty FIFO
    repeat (5) tick();
    rd_cnt = 0;
    v_cnt = 0;
    repeat (100) tick();
    chk("t3_no_pop", rd_cnt, 32'd0);
    chk("t3_no_valid", v_cnt, 32'd0);

    // reset during LATCH
    push(8'hAA);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (fifo_rd_en) seen = 1;
    end
    chk("t4_rd_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_n = 0;
    sb_part = 16'h0;
    @(negedge clk);
    chk("t4_cs", {31'd0, fifo_rd_cs}, 32'd0);
    chk("t4_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t4_data", {16'd0, word_data}, 32'd0);
    chk("t4_bytes", {28'd0, word_bytes}, 32'd0);
    chk("t4_valid", {31'd0, word_valid}, 32'd0);
    tick();
    push(8'h11);
    push(8'h22);
    drain(100);

    // lone byte: flushed with the timeout, otherwise held
    v_cnt = 0;
    push(8'h5C);
`ifdef FIFO_WORD_TIMEOUT_EN
    exp_q.push_back('{d: 16'h005C, n: 4'd1});
    sb_n = 0;
    sb_part = 16'h0;
    drain(60);
    chk("t5_vcycles", v_cnt, 32'd1);
`else
    repeat (60) tick();
    chk("t5_no_valid", v_cnt, 32'd0);
    push(8'h77);
    drain(100);
`endif

    // random pairs with random backpressure
    for (int k = 0; k < 700; k++) begin
      word_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom_range(0, 255));
        push(b);
        word_ready = 1'($urandom_range(0, 1));
        b = 8'($urandom_range(0, 255));
        push(b);
      end else begin
        tick();
      end
    end
    word_ready = 1'b1;
    drain(4000);
    repeat (5) tick();
    chk("t6_fifo_empty", fq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
